// File: rtl/uart_tx_scheduler_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM encoding, UART constants
// and an index-width helper.
`timescale 1ns/1ps
package uart_tx_scheduler_pkg;

  localparam int CLKS_PER_BIT = 16;
  localparam int UART_DATA_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;

  // Smallest r with 2**r >= v; callers pass v >= 2 so the result is at least 1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Bundle between the requesters, the scheduler and the UART transmitter.
`timescale 1ns/1ps
interface uart_tx_scheduler_if
  import uart_tx_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = UART_DATA_W
);
  // Handshake: req[i] is a level held until done[i] or err; gnt is one-hot from grant
  // to done/err; tx_transmit is a single-cycle pulse and tx_data/tx_par_en stay stable
  // until the UART drops tx_busy; done/err are single-cycle pulses, never together.
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_par_en;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        done;
  logic                      err;
  logic                      tx_transmit;
  logic [DATA_W-1:0]         tx_data;
  logic                      tx_par_en;
  logic                      tx_busy;
  state_t                    state;

  modport master (
    output req, req_data, req_par_en, tx_busy,
    input  gnt, done, err, tx_transmit, tx_data, tx_par_en, state
  );

  modport slave (
    input  req, req_data, req_par_en, tx_busy,
    output gnt, done, err, tx_transmit, tx_data, tx_par_en, state
  );

endinterface

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first set req bit at or after ptr, wrapping.
`timescale 1ns/1ps
module uart_tx_scheduler_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               valid,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx
);
  localparam int SUM_W = IDX_W + 1;

  logic [SUM_W-1:0] sum;
  logic [IDX_W-1:0] cand;

  always_comb begin
    valid = 1'b0;
    grant = '0;
    idx   = '0;
    sum   = '0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      // ptr + i can reach 2*NUM_REQ-2, so one conditional subtract is a full modulo
      sum = {1'b0, ptr} + SUM_W'(i);
      if (sum >= SUM_W'(NUM_REQ)) sum = sum - SUM_W'(NUM_REQ);
      cand = sum[IDX_W-1:0];
      if (!valid && req[cand]) begin
        valid       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter among NUM_REQ requesters, one full frame per grant,
// with round-robin fairness and a start timeout when busy never rises.
`timescale 1ns/1ps
module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int DATA_W        = UART_DATA_W,
  parameter int START_TIMEOUT = 8
) (
  input logic                CLK,
  input logic                RST,
  uart_tx_scheduler_if.slave bus
);
  localparam int IDX_W = clog2(NUM_REQ);
  localparam int CNT_W = clog2(START_TIMEOUT);

  state_t             state, state_n;
  logic [IDX_W-1:0]   ptr, ptr_n;
  logic [IDX_W-1:0]   win, win_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [NUM_REQ-1:0] gnt_n, done_n;
  logic               err_n, xmit_n, par_n;
  logic [DATA_W-1:0]  data_n, sel_data;

  logic               arb_valid;
  logic [NUM_REQ-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx;

  uart_tx_scheduler_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req   (bus.req),
    .ptr   (ptr),
    .valid (arb_valid),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (arb_idx == IDX_W'(i)) sel_data = bus.req_data[i*DATA_W +: DATA_W];
  end

  assign bus.state = state;

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    win_n   = win;
    cnt_n   = cnt;
    gnt_n   = bus.gnt;
    done_n  = '0;
    err_n   = 1'b0;
    xmit_n  = 1'b0;
    data_n  = bus.tx_data;
    par_n   = bus.tx_par_en;
    case (state)
      ST_IDLE: begin
        // A busy UART (e.g. a frame left over from before reset) blocks granting
        if (arb_valid && !bus.tx_busy) begin
          gnt_n   = arb_grant;
          win_n   = arb_idx;
          data_n  = sel_data;
          par_n   = bus.req_par_en[arb_idx];
          ptr_n   = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + IDX_W'(1);
          state_n = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        xmit_n  = 1'b1;
        cnt_n   = '0;
        state_n = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (bus.tx_busy) begin
          state_n = ST_WAIT_DONE;
        end else if (cnt == CNT_W'(START_TIMEOUT - 1)) begin
          err_n   = 1'b1;
          gnt_n   = '0;
          data_n  = '0;
          par_n   = 1'b0;
          state_n = ST_IDLE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!bus.tx_busy) begin
          done_n[win] = 1'b1;
          gnt_n       = '0;
          state_n     = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state           <= ST_IDLE;
      ptr             <= '0;
      win             <= '0;
      cnt             <= '0;
      bus.gnt         <= '0;
      bus.done        <= '0;
      bus.err         <= 1'b0;
      bus.tx_transmit <= 1'b0;
      bus.tx_data     <= '0;
      bus.tx_par_en   <= 1'b0;
    end else begin
      state           <= state_n;
      ptr             <= ptr_n;
      win             <= win_n;
      cnt             <= cnt_n;
      bus.gnt         <= gnt_n;
      bus.done        <= done_n;
      bus.err         <= err_n;
      bus.tx_transmit <= xmit_n;
      bus.tx_data     <= data_n;
      bus.tx_par_en   <= par_n;
    end
  end

endmodule
